// File: rtl/rp_scope_dec.sv
//==============================================================================
// Module      : rp_scope_dec
// Description : Scope sample decimator. Emits one sample per N inputs, either
//               the last sample of the window or the shifted, saturated sum.
//               Optional macro SCOPE_DEC_ROUND_EN rounds the average half up.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module rp_scope_dec #(
  parameter int DBITS = 16,
  parameter int CBITS = 17
) (
  input  logic             adc_clk_i,
  input  logic             adc_rst_i,
  input  logic [DBITS-1:0] dec_dat_i,
  input  logic             dec_din_tvalid_i,
  output logic [DBITS-1:0] dec_dat_o,
  output logic             dec_dout_tvalid_o,
  input  logic [CBITS-1:0] cfg_dec_i,
  input  logic [4:0]       cfg_shift_i,
  input  logic             cfg_avg_en_i,
  input  logic             dec_clr_i
);

  localparam int c_ABITS = DBITS + CBITS;
  localparam logic signed [c_ABITS-1:0] c_SAT_MAX = c_ABITS'((2**(DBITS-1)) - 1);
  localparam logic signed [c_ABITS-1:0] c_SAT_MIN = c_ABITS'(-(2**(DBITS-1)));

  // Stage 1: window counter, accumulator and per-window configuration
  logic        [CBITS-1:0]   r_cnt;
  logic        [CBITS-1:0]   r_last_idx;
  logic signed [c_ABITS-1:0] r_acc;
  logic        [DBITS-1:0]   r_last;
  logic                      r_end;
  logic        [4:0]         r_shift;
  logic                      r_avg;

  // Stage 2: output registers
  logic        [DBITS-1:0]   r_dat;
  logic                      r_vld;

  logic                      w_first;
  logic        [CBITS-1:0]   w_n_eff;
  logic        [CBITS-1:0]   w_last_idx;
  logic                      w_wrap;
  logic signed [c_ABITS-1:0] w_din_ext;
  logic signed [c_ABITS-1:0] w_sum;
  logic signed [c_ABITS-1:0] w_shifted;
  logic        [DBITS-1:0]   w_avg;
  logic                      w_fire;

  // The first sample of a window must see the new factor, so bypass the latch.
  assign w_first    = (r_cnt == '0);
  assign w_n_eff    = (cfg_dec_i == '0) ? CBITS'(1) : cfg_dec_i;
  assign w_last_idx = w_first ? (w_n_eff - CBITS'(1)) : r_last_idx;
  assign w_wrap     = (r_cnt == w_last_idx);
  assign w_din_ext  = {{CBITS{dec_dat_i[DBITS-1]}}, dec_dat_i};

`ifdef SCOPE_DEC_ROUND_EN
  logic signed [c_ABITS-1:0] w_rnd;
  assign w_rnd = (r_shift == 5'd0) ? '0 : (c_ABITS'(1) << (r_shift - 5'd1));
  assign w_sum = r_acc + w_rnd;
`else
  assign w_sum = r_acc;
`endif

  assign w_shifted = w_sum >>> r_shift;
  assign w_fire    = r_end & ~dec_clr_i;

  always_comb begin
    w_avg = w_shifted[DBITS-1:0];
    if (w_shifted > c_SAT_MAX) begin
      w_avg = c_SAT_MAX[DBITS-1:0];
    end else if (w_shifted < c_SAT_MIN) begin
      w_avg = c_SAT_MIN[DBITS-1:0];
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_cnt      <= '0;
      r_last_idx <= '0;
      r_acc      <= '0;
      r_last     <= '0;
      r_end      <= 1'b0;
      r_shift    <= '0;
      r_avg      <= 1'b0;
    end else if (dec_clr_i) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_end <= 1'b0;
    end else if (dec_din_tvalid_i) begin
      if (w_first) begin
        r_last_idx <= w_last_idx;
        r_shift    <= cfg_shift_i;
        r_avg      <= cfg_avg_en_i;
        r_acc      <= w_din_ext;
      end else begin
        r_acc <= r_acc + w_din_ext;
      end
      r_last <= dec_dat_i;
      r_end  <= w_wrap;
      r_cnt  <= w_wrap ? '0 : (r_cnt + CBITS'(1));
    end else begin
      r_end <= 1'b0;
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_dat <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= w_fire;
      if (w_fire) begin
        r_dat <= r_avg ? w_avg : r_last;
      end
    end
  end

  assign dec_dat_o         = r_dat;
  assign dec_dout_tvalid_o = r_vld;

endmodule

`default_nettype wire

// File: tb/tb_rp_scope_dec.sv
//==============================================================================
// Module      : tb_rp_scope_dec
// Description : Directed scoreboard bench for rp_scope_dec.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_rp_scope_dec;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] din;
  logic               vin;
  logic        [15:0] dout;
  logic               vout;
  logic        [16:0] cfg_dec;
  logic        [4:0]  cfg_shift;
  logic               cfg_avg;
  logic               clr;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [15:0] d;
    int                 due;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rp_scope_dec #(.DBITS(16), .CBITS(17)) dut (
    .adc_clk_i         (clk),
    .adc_rst_i         (rst),
    .dec_dat_i         (din),
    .dec_din_tvalid_i  (vin),
    .dec_dat_o         (dout),
    .dec_dout_tvalid_o (vout),
    .cfg_dec_i         (cfg_dec),
    .cfg_shift_i       (cfg_shift),
    .cfg_avg_en_i      (cfg_avg),
    .dec_clr_i         (clr)
  );

  task automatic step(input logic signed [15:0] d, input logic v,
                      input logic c = 1'b0, input logic r = 1'b0);
    din = d; vin = v; clr = c; rst = r;
    @(posedge clk);
    #1;
    vin = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  // Result due one edge after the edge that accepted the window's last sample
  task automatic push_exp(input logic signed [15:0] d);
    exp_t e;
    e.d   = d;
    e.due = cyc + 1;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (vout === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        assert (vout === 1'b0) else begin
          errors++;
          $error("FAIL unexpected_strobe observed=%0d expected=no strobe (cyc %0d)", $signed(dout), cyc);
        end
      end else begin
        e = q.pop_front();
        checks++;
        assert (dout === e.d) else begin
          errors++;
          $error("FAIL data observed=%0d expected=%0d (cyc %0d)", $signed(dout), e.d, cyc);
        end
        checks++;
        assert (cyc === e.due) else begin
          errors++;
          $error("FAIL latency observed_cyc=%0d expected_cyc=%0d", cyc, e.due);
        end
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      assert (vout === 1'b1) else begin
        errors++;
        $error("FAIL missing_strobe observed=%b expected=1 for data %0d (cyc %0d)", vout, e.d, cyc);
      end
    end
  end

  initial begin
    din = '0; vin = 1'b0; clr = 1'b0; rst = 1'b1;
    cfg_dec = 17'd1; cfg_shift = 5'd0; cfg_avg = 1'b0;
    repeat (3) step(0, 1'b0, 1'b0, 1'b1);
    checks++;
    assert (vout === 1'b0 && dout === 16'd0) else begin
      errors++;
      $error("FAIL reset_state observed=%b/%0d expected=0/0", vout, dout);
    end

    // N=1 pick, back-to-back samples
    cfg_dec = 17'd1; cfg_avg = 1'b0;
    step(100, 1'b1);   push_exp(100);
    step(-5, 1'b1);    push_exp(-5);
    step(32767, 1'b1); push_exp(32767);
    repeat (3) step(0, 1'b0);

    // N=4 average, shift 2
    cfg_dec = 17'd4; cfg_avg = 1'b1; cfg_shift = 5'd2;
    step(10, 1'b1); step(20, 1'b1); step(30, 1'b1);
    step(40, 1'b1); push_exp(25);
    repeat (3) step(-8, 1'b1);
    step(-8, 1'b1); push_exp(-8);
    repeat (3) step(0, 1'b0);

    // N=4 pick
    cfg_avg = 1'b0;
    step(1, 1'b1); step(2, 1'b1); step(3, 1'b1);
    step(4, 1'b1); push_exp(4);
    repeat (3) step(0, 1'b0);

    // N=2 saturation both ways
    cfg_dec = 17'd2; cfg_avg = 1'b1; cfg_shift = 5'd0;
    step(32767, 1'b1);  step(32767, 1'b1);  push_exp(32767);
    step(-32768, 1'b1); step(-32768, 1'b1); push_exp(-32768);
    repeat (3) step(0, 1'b0);

    // N=3 with gaps in valid
    cfg_dec = 17'd3;
    step(3, 1'b1); step(1234, 1'b0); step(6, 1'b1); step(-999, 1'b0);
    step(9, 1'b1); push_exp(18);
    repeat (3) step(0, 1'b0);

    // Clear mid-window discards the partial window and the coincident sample
    cfg_dec = 17'd4; cfg_shift = 5'd2;
    step(4, 1'b1); step(8, 1'b1); step(12, 1'b1, 1'b1);
    step(4, 1'b1); step(8, 1'b1); step(12, 1'b1);
    step(16, 1'b1); push_exp(10);
    repeat (3) step(0, 1'b0);

    // Reset mid-window
    step(4, 1'b1); step(8, 1'b1); step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0);
    checks++;
    assert (vout === 1'b0 && dout === 16'd0) else begin
      errors++;
      $error("FAIL reset_mid_window observed=%b/%0d expected=0/0", vout, dout);
    end
    step(1, 1'b1); step(2, 1'b1); step(3, 1'b1);
    step(6, 1'b1); push_exp(3);
    repeat (3) step(0, 1'b0);

    // Rounding behaviour, N=2 shift 1
    cfg_dec = 17'd2; cfg_shift = 5'd1; cfg_avg = 1'b1;
`ifdef SCOPE_DEC_ROUND_EN
    step(1, 1'b1);  step(2, 1'b1);  push_exp(2);
    step(-1, 1'b1); step(-2, 1'b1); push_exp(-1);
`else
    step(1, 1'b1);  step(2, 1'b1);  push_exp(1);
    step(-1, 1'b1); step(-2, 1'b1); push_exp(-2);
`endif
    repeat (3) step(0, 1'b0);

    // Config change mid-window only applies to the next window
    cfg_dec = 17'd2; cfg_shift = 5'd0; cfg_avg = 1'b1;
    step(5, 1'b1);
    cfg_dec = 17'd1; cfg_shift = 5'd3; cfg_avg = 1'b0;
    step(7, 1'b1); push_exp(12);
    step(9, 1'b1); push_exp(9);
    repeat (3) step(0, 1'b0);

    // Factor 0 behaves as 1
    cfg_dec = 17'd0;
    step(77, 1'b1); push_exp(77);
    step(-1, 1'b1); push_exp(-1);
    repeat (5) step(0, 1'b0);

    checks++;
    assert (q.size() === 0) else begin
      errors++;
      $error("FAIL drain observed=%0d pending expected=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
